tdc_readout: RTL and testbench
==============================

# tdc_readout

Sequential read-back controller for the ring TDC's 8-bit muxed result port. It sits on the far side of the byte-select interface. On a trigger it walks the 5-bit select through every result byte and waits a programmable settle time per byte. It then reduces the captured thermometer word to a one-count, an edge position and a bubble flag, and presents these on a valid/ready handshake.

## Interface
Parameters:
- N_DELAY, 192: TDC delay stages. Multiple of 8, maximum 256.
- SETTLE, 1: wait cycles after each select change before a byte is captured. Range 0–15.
- CW, $clog2(N_DELAY+1): width of the count and edge outputs.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- i_trig, input, 1: start a readout. Sampled only in IDLE.
- o_sel, output, 5: byte select to the TDC mux.
- i_byte, input, 8: selected result byte, bits [8·sel+7 : 8·sel].
- o_busy, output, 1: high from trigger acceptance until o_valid rises.
- o_valid, output, 1: result available.
- i_ready, input, 1: consumer accepts the result.
- o_count, output, CW: number of ones in the N_DELAY-bit word.
- o_edge, output, CW: index of the first bit whose value differs from bit 0; N_DELAY if there is none.
- o_bubble, output, 1: more than one value transition across the word.

## Operation
- N_BYTES = N_DELAY/8.
- States:
  - IDLE: on i_trig go to WAIT. Set o_sel=0, clear accumulators, load the settle counter with SETTLE.
  - WAIT: decrement the counter. Go to CAPT when it is 0. With SETTLE=0, WAIT is skipped and IDLE goes directly to CAPT.
  - CAPT: fold i_byte into the accumulators. If o_sel==N_BYTES-1 go to DONE. Otherwise increment o_sel, reload the counter and go to WAIT (or CAPT if SETTLE=0).
  - DONE: o_valid=1. On i_ready go to IDLE.
- Accumulation, per byte, LSB first:
  - count += popcount(i_byte).
  - The reference bit is bit 0 of byte 0, latched in the byte-0 CAPT cycle.
  - Transitions are counted between adjacent bits, including across byte boundaries via the stored previous bit.
  - The edge is recorded at the first transition only.
- o_count, o_edge and o_bubble are registered. They stay stable throughout DONE and change only on the next trigger's byte-0 capture.
- i_trig is ignored in every state except IDLE; no queueing.
- A trigger pulse shorter than one cycle is not supported. The caller synchronises i_trig.
- o_sel returns to 0 in IDLE and in DONE.

## Timing
- Reset values: o_sel=0, o_busy=0, o_valid=0, o_count=0, o_edge=N_DELAY, o_bubble=0, state IDLE.
- Latency: o_valid rises N_BYTES·(SETTLE+1)+1 edges after the accepting edge. For the defaults this is 49.
- o_busy falls on the same edge that o_valid rises.
- Handshake: the transfer completes on an edge with o_valid & i_ready. o_valid falls on that edge. A new i_trig is accepted no earlier than the following edge.
- i_ready may be held high permanently; DONE then lasts exactly one cycle.
- Reset mid-readout: IDLE on the next edge, all outputs at reset values, the partial result discarded.
- A reset asserted in the same cycle as i_trig wins.
- Count saturation cannot occur: CW covers N_DELAY.

## Configuration
- Macro TDC_READOUT_BUBBLE_EN.
- Defined: transition counting is built; o_bubble is reported as specified.
- Undefined: the transition counter is omitted and o_bubble is tied to 0. o_edge is still the first transition.

## Structure
- Package tdc_readout_pkg holds:
  - state encoding (IDLE, WAIT, CAPT, DONE);
  - the N_BYTES derivation;
  - the maximum SETTLE width constant.
- Sub-module tdc_byte_stats (combinational) takes a byte and the previous bit. It returns the popcount, a first-transition-found flag with bit offset, the transition count and the last bit. Instantiate it once, in the CAPT datapath.

## Test plan
- All-zero word, defaults, trigger once → o_valid at edge 49; o_count=0, o_edge=192, o_bubble=0; o_sel sequence 0..23, each value held 2 cycles.
- Bits 0..49=1, rest 0 → o_count=50, o_edge=50, o_bubble=0.
- Bits 0..9=1 plus bit 20=1 → o_count=11, o_edge=10. o_bubble=1 with the macro defined, 0 without.
- i_ready held low 5 cycles in DONE, i_trig pulsed during DONE → o_valid and outputs stable, trigger ignored, clean return to IDLE after i_ready.
- rst asserted while o_sel=7 → next edge o_sel=0, o_busy=0, o_valid=0; a fresh trigger yields the correct result.
- SETTLE=0, N_DELAY=64, all ones → o_valid at edge 9; o_count=64, o_edge=64, o_bubble=0.

Source files
------------

// File: rtl/tdc_readout_pkg.sv
// -----------------------------------------------------------------------------
// tdc_readout_pkg
// Shared definitions for the ring-TDC read-back controller:
//   - state_t   : controller state encoding (IDLE, WAIT, CAPT, DONE)
//   - SETTLE_W  : width of the settle counter (SETTLE range 0..15)
//   - calc_n_bytes() : number of result bytes for a given delay-line length
// -----------------------------------------------------------------------------
package tdc_readout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int calc_n_bytes(input int n_delay);
    return n_delay / 8;
  endfunction

endpackage

// File: rtl/tdc_readout_byte_stats.sv
// -----------------------------------------------------------------------------
// tdc_byte_stats
// Combinational statistics for one thermometer byte, scanned LSB first.
// Ports:
//   data   in  8 : result byte
//   prev   in  1 : value of the bit just below data[0] (previous byte's MSB)
//   pop    out 4 : number of ones in data
//   found  out 1 : a transition exists inside this byte (including prev->data[0])
//   offset out 3 : bit position of the first such transition
//   trans  out 4 : number of transitions (only with TDC_READOUT_BUBBLE_EN)
//   last   out 1 : data[7], becomes prev for the next byte
// Macro TDC_READOUT_BUBBLE_EN adds the trans output.
// -----------------------------------------------------------------------------
module tdc_byte_stats (
  input  logic [7:0] data,
  input  logic       prev,
  output logic [3:0] pop,
  output logic       found,
  output logic [2:0] offset,
`ifdef TDC_READOUT_BUBBLE_EN
  output logic [3:0] trans,
`endif
  output logic       last
);

  logic p;

  always_comb begin
    pop    = '0;
    found  = 1'b0;
    offset = '0;
`ifdef TDC_READOUT_BUBBLE_EN
    trans  = '0;
`endif
    p      = prev;
    for (int i = 0; i < 8; i++) begin
      pop = pop + 4'(data[i]);
      if (data[i] != p) begin
`ifdef TDC_READOUT_BUBBLE_EN
        trans = trans + 4'd1;
`endif
        if (!found) begin
          found  = 1'b1;
          offset = 3'(i);
        end
      end
      p = data[i];
    end
  end

  assign last = data[7];

endmodule

// File: rtl/tdc_readout.sv
// -----------------------------------------------------------------------------
// tdc_readout
// Read-back controller for the ring TDC's 8-bit muxed result port. On a
// trigger it steps o_sel through every result byte, waits SETTLE cycles after
// each select change, folds the byte into running statistics and finally
// presents one-count, first-edge position and bubble flag on valid/ready.
//
// Handshake: o_valid stays high with stable o_count/o_edge/o_bubble until an
// edge with o_valid & i_ready; that edge completes the transfer and drops
// o_valid. i_trig is only sampled in IDLE.
//
// Ports:
//   clk, rst (sync, active high)
//   i_trig          : start a readout (IDLE only)
//   o_sel    [4:0]  : byte select to the TDC mux
//   i_byte   [7:0]  : selected result byte
//   o_busy          : readout in progress
//   o_valid/i_ready : result handshake
//   o_count  [CW-1:0], o_edge [CW-1:0], o_bubble : result
//   o_state  [1:0]  : current controller state (debug)
// Macro TDC_READOUT_BUBBLE_EN builds the transition counter behind o_bubble;
// without it o_bubble is tied low and only the first edge is tracked.
// -----------------------------------------------------------------------------
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int N_DELAY = 192,
  parameter int SETTLE  = 1,
  parameter int CW      = $clog2(N_DELAY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_trig,
  output logic [4:0]    o_sel,
  input  logic [7:0]    i_byte,
  output logic          o_busy,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [CW-1:0] o_count,
  output logic [CW-1:0] o_edge,
  output logic          o_bubble,
  output logic [1:0]    o_state
);

  localparam int N_BYTES = calc_n_bytes(N_DELAY);
  localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE);
  // With no settle time a select change is followed directly by a capture.
  localparam state_t NEXT_AFTER_SEL = (SETTLE == 0) ? ST_CAPT : ST_WAIT;

  state_t              state;
  logic [SETTLE_W-1:0] cnt;
  logic                found_q;
  logic                prev_q;

  // Byte-0 capture restarts all statistics, so results from the previous
  // readout stay visible until that point.
  logic                first_byte;
  logic                last_byte;
  logic                ref_prev;
  logic [3:0]          b_pop;
  logic                b_found;
  logic [2:0]          b_offset;
  logic                b_last;
  logic [CW-1:0]       edge_here;

  assign first_byte = (o_sel == 5'd0);
  assign last_byte  = (o_sel == 5'(N_BYTES - 1));
  // For byte 0 the reference is bit 0 itself, so bit 0 never counts as a transition.
  assign ref_prev   = first_byte ? i_byte[0] : prev_q;
  assign edge_here  = CW'({o_sel, b_offset});
  assign o_state    = state;

`ifdef TDC_READOUT_BUBBLE_EN
  logic [3:0] b_trans;
`endif

  tdc_byte_stats u_stats (
    .data   (i_byte),
    .prev   (ref_prev),
    .pop    (b_pop),
    .found  (b_found),
    .offset (b_offset),
`ifdef TDC_READOUT_BUBBLE_EN
    .trans  (b_trans),
`endif
    .last   (b_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      o_sel   <= '0;
      cnt     <= '0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_count <= '0;
      o_edge  <= CW'(N_DELAY);
      found_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          o_sel <= '0;
          if (i_trig) begin
            cnt    <= SETTLE_LD;
            o_busy <= 1'b1;
            state  <= NEXT_AFTER_SEL;
          end
        end

        ST_WAIT: begin
          cnt <= cnt - SETTLE_W'(1);
          if (cnt == SETTLE_W'(1)) state <= ST_CAPT;
        end

        ST_CAPT: begin
          prev_q <= b_last;
          if (first_byte) begin
            o_count <= CW'(b_pop);
            found_q <= b_found;
            o_edge  <= b_found ? edge_here : CW'(N_DELAY);
          end else begin
            o_count <= o_count + CW'(b_pop);
            if (!found_q && b_found) begin
              found_q <= 1'b1;
              o_edge  <= edge_here;
            end
          end

          if (last_byte) begin
            o_sel   <= '0;
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            state   <= ST_DONE;
          end else begin
            o_sel <= o_sel + 5'd1;
            cnt   <= SETTLE_LD;
            state <= NEXT_AFTER_SEL;
          end
        end

        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TDC_READOUT_BUBBLE_EN
  // Only "more than one transition" matters, so the tally saturates at 2.
  logic [1:0] trans_q;
  logic [3:0] trans_sum;

  assign trans_sum = (first_byte ? 4'd0 : {2'b00, trans_q}) + b_trans;

  always_ff @(posedge clk) begin
    if (rst) begin
      trans_q <= '0;
    end else if (state == ST_CAPT) begin
      trans_q <= (trans_sum > 4'd2) ? 2'd2 : trans_sum[1:0];
    end
  end

  assign o_bubble = trans_q[1];
`else
  assign o_bubble = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_readout.sv
// -----------------------------------------------------------------------------
// tb_tdc_readout
// Two instances: dut_a with default parameters (192 stages, SETTLE=1) and
// dut_b with 64 stages and SETTLE=0. Each models the TDC result port as a
// word indexed by o_sel. Expected results come from a whole-word reference
// model and are queued at trigger acceptance; monitors pop them on transfer.
// Edge counting: the accepting edge is edge 1.
// -----------------------------------------------------------------------------
module tb_tdc_readout;
  import tdc_readout_pkg::*;

  localparam int NA = 192;
  localparam int NB = 64;
  localparam int LAT_A = (NA / 8) * (1 + 1) + 1;
  localparam int LAT_B = (NB / 8) * (0 + 1) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT A ----------------
  logic          trig_a = 1'b0, ready_a = 1'b1;
  logic [4:0]    sel_a;
  logic [7:0]    byte_a;
  logic          busy_a, valid_a, bubble_a;
  logic [7:0]    count_a, edge_a;
  logic [1:0]    state_a;
  logic [NA-1:0] word_a = '0;
  assign byte_a = word_a[8*sel_a +: 8];

  tdc_readout #(.N_DELAY(NA), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .i_trig(trig_a), .o_sel(sel_a), .i_byte(byte_a),
    .o_busy(busy_a), .o_valid(valid_a), .i_ready(ready_a),
    .o_count(count_a), .o_edge(edge_a), .o_bubble(bubble_a), .o_state(state_a)
  );

  // ---------------- DUT B ----------------
  logic          trig_b = 1'b0, ready_b = 1'b1;
  logic [4:0]    sel_b;
  logic [7:0]    byte_b;
  logic          busy_b, valid_b, bubble_b;
  logic [6:0]    count_b, edge_b;
  logic [1:0]    state_b;
  logic [NB-1:0] word_b = '0;
  assign byte_b = word_b[8*sel_b[2:0] +: 8];

  tdc_readout #(.N_DELAY(NB), .SETTLE(0)) dut_b (
    .clk(clk), .rst(rst), .i_trig(trig_b), .o_sel(sel_b), .i_byte(byte_b),
    .o_busy(busy_b), .o_valid(valid_b), .i_ready(ready_b),
    .o_count(count_b), .o_edge(edge_b), .o_bubble(bubble_b), .o_state(state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q_a[$];
  logic [18:0] exp_q_b[$];
  logic [18:0] e_a, e_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {count[8:0], edge[8:0], bubble} from the whole word.
  function automatic logic [18:0] ref_model(input logic [255:0] w, input int n);
    int cnt, edg, tr;
    logic bub;
    cnt = 0; edg = n; tr = 0;
    for (int i = 0; i < n; i++) begin
      cnt += int'(w[i]);
      if (edg == n && w[i] != w[0]) edg = i;
      if (i > 0 && w[i] != w[i-1]) tr++;
    end
`ifdef TDC_READOUT_BUBBLE_EN
    bub = (tr > 1);
`else
    bub = 1'b0;
`endif
    return {9'(cnt), 9'(edg), bub};
  endfunction

  // Monitors: a transfer is an edge with valid & ready; sample mid-cycle.
  always @(negedge clk) begin
    if (!rst && valid_a && ready_a) begin
      if (exp_q_a.size() == 0) check("sb_a_unexpected", 1, 0);
      else begin
        e_a = exp_q_a.pop_front();
        check("sb_a_result", {45'd0, 9'(count_a), 9'(edge_a), bubble_a}, {45'd0, e_a});
      end
    end
    if (!rst && valid_b && ready_b) begin
      if (exp_q_b.size() == 0) check("sb_b_unexpected", 1, 0);
      else begin
        e_b = exp_q_b.pop_front();
        check("sb_b_result", {45'd0, 9'(count_b), 9'(edge_b), bubble_b}, {45'd0, e_b});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [NA-1:0] thermo_a(input int e, input bit inv, input bit flip);
    logic [NA-1:0] w;
    for (int i = 0; i < NA; i++) w[i] = (i < e) ^ inv;
    if (flip) w[$urandom_range(0, NA-1)] ^= 1'b1;
    return w;
  endfunction

  // Full readout on dut_a; stall = cycles with i_ready low in DONE (trigger
  // pulsed during the stall); chk_sel verifies the select sequence.
  task automatic readout_a(input logic [NA-1:0] w, input int stall, input bit chk_sel);
    int k, sel_err;
    logic [16:0] snap;
    word_a  = w;
    ready_a = (stall == 0);
    @(posedge clk); #1;
    trig_a = 1'b1;
    @(posedge clk); #1;                       // accepting edge = edge 1
    trig_a = 1'b0;
    exp_q_a.push_back(ref_model(256'(w), NA));
    k = 1; sel_err = 0;
    if (chk_sel && sel_a != 5'd0) sel_err++;
    while (!valid_a && k < 200) begin
      @(posedge clk); #1;
      k++;
      if (chk_sel && !valid_a && sel_a != 5'((k - 1) / 2)) sel_err++;
    end
    check("latency_a", 64'(k), 64'(LAT_A));
    check("busy_falls_with_valid_a", {63'd0, busy_a}, 0);
    check("sel_zero_in_done_a", 64'(sel_a), 0);
    if (chk_sel) check("sel_sequence_a", 64'(sel_err), 0);
    if (stall > 0) begin
      snap = {count_a, edge_a, bubble_a};
      for (int s = 0; s < stall; s++) begin
        trig_a = (s == 0);
        @(posedge clk); #1;
        trig_a = 1'b0;
        check("stall_stable_a", {46'd0, valid_a, count_a, edge_a, bubble_a}, {46'd0, 1'b1, snap});
      end
      check("trig_ignored_in_done_a", {62'd0, busy_a, state_a == ST_DONE}, 64'd1);
      ready_a = 1'b1;
    end
    @(posedge clk); #1;                       // handshake edge
    check("valid_drops_a", {62'd0, valid_a, busy_a}, 0);
    check("idle_after_a", 64'(state_a), 64'(ST_IDLE));
  endtask

  task automatic readout_b(input logic [NB-1:0] w);
    int k;
    word_b = w;
    @(posedge clk); #1;
    trig_b = 1'b1;
    @(posedge clk); #1;
    trig_b = 1'b0;
    exp_q_b.push_back(ref_model(256'(w), NB));
    k = 1;
    while (!valid_b && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency_b", 64'(k), 64'(LAT_B));
    check("busy_falls_with_valid_b", {63'd0, busy_b}, 0);
    @(posedge clk); #1;
    check("valid_drops_b", {63'd0, valid_b}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    logic [NA-1:0] w;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_a", {45'd0, sel_a, busy_a, valid_a, count_a, edge_a, bubble_a, state_a},
          {45'd0, 5'd0, 1'b0, 1'b0, 8'd0, 8'(NA), 1'b0, 2'(ST_IDLE)});
    check("reset_b", {47'd0, sel_b, busy_b, valid_b, count_b, edge_b, bubble_b},
          {47'd0, 5'd0, 1'b0, 1'b0, 7'd0, 7'(NB), 1'b0});

    // All-zero word with select-sequence check.
    readout_a('0, 0, 1'b1);
    // Bits 0..49 set.
    readout_a(thermo_a(50, 1'b0, 1'b0), 0, 1'b0);
    // Bits 0..9 plus bit 20: three transitions.
    w = thermo_a(10, 1'b0, 1'b0);
    w[20] = 1'b1;
    readout_a(w, 0, 1'b0);
    // Stall in DONE for 5 cycles with a trigger during the stall.
    readout_a(thermo_a(77, 1'b1, 1'b0), 5, 1'b0);
    // All ones: no edge.
    readout_a('1, 0, 1'b0);

    // Reset while o_sel == 7.
    word_a = thermo_a(100, 1'b0, 1'b0);
    @(posedge clk); #1;
    trig_a = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    t = 0;
    while (sel_a != 5'd7 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_sel7", 64'(sel_a), 7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset_a", {45'd0, sel_a, busy_a, valid_a, count_a, edge_a, bubble_a, state_a},
          {45'd0, 5'd0, 1'b0, 1'b0, 8'd0, 8'(NA), 1'b0, 2'(ST_IDLE)});
    readout_a(thermo_a(100, 1'b0, 1'b0), 0, 1'b0);

    // Reset coinciding with a trigger: reset wins.
    trig_a = 1'b1;
    rst    = 1'b1;
    @(posedge clk); #1;
    trig_a = 1'b0;
    rst    = 1'b0;
    check("reset_beats_trig", {62'd0, busy_a, state_a != ST_IDLE}, 0);

    // Randomized thermometer words, some with a flipped bit, random stalls.
    for (int r = 0; r < 10; r++)
      readout_a(thermo_a($urandom_range(0, NA), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1))), $urandom_range(0, 3), 1'b0);
    // Fully random words.
    for (int r = 0; r < 3; r++)
      readout_a({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0);

    // Second instance: SETTLE=0, 64 stages.
    readout_b('1);
    readout_b(64'h0000_0000_0000_0fff);
    for (int r = 0; r < 4; r++) readout_b({$urandom(), $urandom()});

    repeat (3) @(posedge clk);
    #1;
    check("queue_a_drained", 64'(exp_q_a.size()), 0);
    check("queue_b_drained", 64'(exp_q_b.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
